// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and defaults for the framed parity checker
package parity_pkg;

  // Receiver frame state: waiting for start, collecting data, expecting parity
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DEFAULT_DATA_W    = 4;
  localparam int DEFAULT_ERR_CNT_W = 8;

  // Bit-index width for a frame of n data bits; at least one bit so a
  // single-bit frame still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over a coincident increment; the count sticks at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - deserialises LSB-first parity frames and flags parity errors
module parity_frame_checker #(
  parameter int DATA_W    = parity_pkg::DEFAULT_DATA_W,
  parameter int ODD       = 0,
  parameter int ERR_CNT_W = parity_pkg::DEFAULT_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 in_sof,
  input  logic                 clr_count,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_err,
  output logic                 abort,
  output logic [ERR_CNT_W-1:0] err_count
);

  import parity_pkg::*;

  localparam int   IDX_W    = idx_width(DATA_W);
  localparam logic ODD_SENSE = (ODD != 0) ? PARITY_ODD : PARITY_EVEN;
  // Where a start bit leads: straight to parity when the frame has one data bit
  localparam state_e AFTER_SOF = (DATA_W == 1) ? PARITY : DATA;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic              abort_q, abort_d;

  logic start;
  logic last_data;

  assign start     = in_valid & in_sof;
  assign last_data = (idx_q == IDX_W'(DATA_W - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= 1'b0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      abort_q     <= abort_d;
    end
  end

  // Next state: a start bit always restarts the frame, otherwise walk the frame
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = AFTER_SOF;
    end else if (in_valid) begin
      case (state_q)
        DATA:    if (last_data) state_d = PARITY;
        PARITY:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and outputs: shift bits in, fold parity, publish on completion
  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    abort_d     = 1'b0;
    if (start) begin
      // Any frame in progress is dropped; this bit is data bit 0 of the new one
      abort_d    = (state_q != IDLE);
      shift_d    = '0;
      shift_d[0] = in_bit;
      acc_d      = in_bit;
      idx_d      = IDX_W'(1);
    end else if (in_valid) begin
      case (state_q)
        DATA: begin
          shift_d[idx_q] = in_bit;
          acc_d          = acc_q ^ in_bit;
          idx_d          = idx_q + IDX_W'(1);
        end
        PARITY: begin
          out_valid_d = 1'b1;
          out_data_d  = shift_q;
          out_err_d   = ((acc_q ^ in_bit) != ODD_SENSE);
          acc_d       = 1'b0;
          idx_d       = '0;
        end
        default: begin
          // Stray bits outside a frame are ignored
        end
      endcase
    end
  end

  // Counts errored frames as they are presented
  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid_q & out_err_q),
    .clr   (clr_count),
    .count (err_count)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - directed self-checking bench for parity_frame_checker
module tb_parity_frame_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_sof;
  logic       clr_count;

  logic       out_valid;
  logic [3:0] out_data;
  logic       out_err;
  logic       abort;
  logic [7:0] err_count;

  logic       o_out_valid;
  logic [3:0] o_out_data;
  logic       o_out_err;
  logic       o_abort;
  logic [7:0] o_err_count;

  int errors;
  int checks;

  parity_frame_checker #(
    .DATA_W    (4),
    .ODD       (0),
    .ERR_CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .clr_count (clr_count),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .abort     (abort),
    .err_count (err_count)
  );

  parity_frame_checker #(
    .DATA_W    (4),
    .ODD       (1),
    .ERR_CNT_W (8)
  ) dut_odd (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .clr_count (clr_count),
    .out_valid (o_out_valid),
    .out_data  (o_out_data),
    .out_err   (o_out_err),
    .abort     (o_abort),
    .err_count (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; returns at the next falling edge,
  // so outputs registered at the accepting rising edge are visible.
  task automatic drive(input logic v, input logic sof, input logic b);
    in_valid = v;
    in_sof   = sof;
    in_bit   = b;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), d[i]);
      if (gaps) idle();
    end
    drive(1'b1, 1'b0, p);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_sof    = 1'b0;
    clr_count = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {28'd0, out_data},  32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    check("rst_abort",     {31'd0, abort},     32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    idle();

    // Good frame B with even parity bit 1
    send_frame(4'hB, 1'b1, 1'b0);
    check("b_ok_valid", {31'd0, out_valid}, 32'd1);
    check("b_ok_data",  {28'd0, out_data},  32'hB);
    check("b_ok_err",   {31'd0, out_err},   32'd0);
    idle();
    check("b_ok_pulse",  {31'd0, out_valid}, 32'd0);
    check("b_ok_cnt",    {24'd0, err_count}, 32'd0);

    // Same data, wrong parity
    send_frame(4'hB, 1'b0, 1'b0);
    check("b_bad_valid", {31'd0, out_valid}, 32'd1);
    check("b_bad_err",   {31'd0, out_err},   32'd1);
    idle();
    check("b_bad_cnt",   {24'd0, err_count}, 32'd1);
    check("hold_data",   {28'd0, out_data},  32'hB);
    check("hold_err",    {31'd0, out_err},   32'd1);

    // Start bit at data bit 2 aborts, then frame 5 (bits 1,0,1,0) parity 0
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("abort_pulse",  {31'd0, abort},     32'd1);
    check("abort_no_out", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    check("abort_end",    {31'd0, abort},     32'd0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    check("abort_still_no_out", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    check("f5_valid", {31'd0, out_valid}, 32'd1);
    check("f5_data",  {28'd0, out_data},  32'h5);
    check("f5_err",   {31'd0, out_err},   32'd0);
    idle();

    // Back-to-back F/p0 then 1/p1, without then with input gaps
    for (int g = 0; g < 2; g++) begin
      send_frame(4'hF, 1'b0, (g == 1));
      check("b2b_f_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_f_data",  {28'd0, out_data},  32'hF);
      check("b2b_f_err",   {31'd0, out_err},   32'd0);
      drive(1'b1, 1'b1, 1'b1);
      check("b2b_gap_low", {31'd0, out_valid}, 32'd0);
      if (g == 1) idle();
      for (int i = 1; i < 4; i++) begin
        drive(1'b1, 1'b0, 1'b0);
        check("b2b_mid_low", {31'd0, out_valid}, 32'd0);
        if (g == 1) idle();
      end
      drive(1'b1, 1'b0, 1'b1);
      check("b2b_1_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_1_data",  {28'd0, out_data},  32'h1);
      check("b2b_1_err",   {31'd0, out_err},   32'd0);
      idle();
    end
    check("b2b_cnt", {24'd0, err_count}, 32'd1);

    // Clear, build up to 7, then clear against a coincident errored frame
    clr_count = 1'b1;
    idle();
    clr_count = 1'b0;
    check("clr_zero", {24'd0, err_count}, 32'd0);
    for (int n = 0; n < 7; n++) send_frame(4'h3, 1'b1, 1'b0);
    idle();
    check("cnt_seven", {24'd0, err_count}, 32'd7);
    send_frame(4'h3, 1'b1, 1'b0);
    check("clr_race_valid", {31'd0, out_valid}, 32'd1);
    check("clr_race_err",   {31'd0, out_err},   32'd1);
    clr_count = 1'b1;
    idle();
    clr_count = 1'b0;
    check("clr_priority", {24'd0, err_count}, 32'd0);

    // 300 errored frames saturate the 8-bit counter
    for (int n = 0; n < 300; n++) send_frame(4'hB, 1'b0, 1'b0);
    idle();
    check("sat_255", {24'd0, err_count}, 32'd255);

    // Odd-parity instance: data 0 with parity 1 is clean, parity 0 is not
    send_frame(4'h0, 1'b1, 1'b0);
    check("odd_ok_valid",  {31'd0, o_out_valid}, 32'd1);
    check("odd_ok_err",    {31'd0, o_out_err},   32'd0);
    check("even_same_err", {31'd0, out_err},     32'd1);
    idle();
    send_frame(4'h0, 1'b0, 1'b0);
    check("odd_bad_err",   {31'd0, o_out_err},   32'd1);
    check("even_ok_err",   {31'd0, out_err},     32'd0);
    idle();

    // Reset in the middle of a frame
    send_frame(4'hB, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data",  {28'd0, out_data},  32'd0);
    check("mid_rst_err",   {31'd0, out_err},   32'd0);
    check("mid_rst_abort", {31'd0, abort},     32'd0);
    check("mid_rst_cnt",   {24'd0, err_count}, 32'd0);
    check("mid_rst_odd_cnt", {24'd0, o_err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    check("post_rst_no_out",   {31'd0, out_valid}, 32'd0);
    idle();
    check("post_rst_no_out2",  {31'd0, out_valid}, 32'd0);
    check("post_rst_no_abort", {31'd0, abort},     32'd0);
    check("post_rst_data",     {28'd0, out_data},  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Receiving end of the team's 5-bit parity scheme: the existing combinational generator produces the XOR of five bits, and this block checks parity on a framed serial stream. Each frame is DATA_W data bits (LSB first) followed by one parity bit. The block deserialises the data, checks parity, presents the word with an error flag, and keeps a saturating error count. It sits between a serial link front-end and word-level consumers.

Parameters:
DATA_W, 4, data bits per frame; the frame is DATA_W+1 bits, so the default frame is 5 bits; legal range 1..32
ODD, 0, parity sense: 0 = even (XOR of all frame bits must be 0), 1 = odd (XOR must be 1)
ERR_CNT_W, 8, width of the saturating parity-error counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_bit/in_sof are sampled this cycle
in_bit  in  1  serial frame bit
in_sof  in  1  qualifies in_valid; marks bit 0 of a new frame
clr_count  in  1  synchronous clear of err_count
out_valid  out  1  one-cycle pulse, frame complete
out_data  out  DATA_W  deserialised data, bit i = i-th received data bit
out_err  out  1  parity mismatch for the frame; valid with out_valid
abort  out  1  one-cycle pulse, partial frame discarded
err_count  out  ERR_CNT_W  frames with out_err=1, saturating

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility): state=IDLE, bit index=0, parity accumulator=0, shift register=0.
- Reset values: out_valid=0, out_data=0, out_err=0, abort=0, err_count=0.
- IDLE state:
  - in_valid & in_sof: store in_bit as data bit 0, acc=in_bit, idx=1, go to DATA. If DATA_W=1, go directly to PARITY.
  - in_valid & ~in_sof: bit dropped silently; no abort, no count change.
- DATA state:
  - in_valid & ~in_sof: store bit at idx, acc^=in_bit, idx++.
  - When the last data bit (idx = DATA_W-1) is accepted, go to PARITY.
  - in_valid=0: hold all state. No timeout.
- PARITY state:
  - in_valid & ~in_sof: next cycle out_valid=1, out_data=shift register, out_err=((acc^in_bit)!=ODD). Go to IDLE.
  - Latency: 1 cycle from parity-bit acceptance to out_valid.
- in_sof in DATA or PARITY:
  - Next cycle abort=1. The partial frame is discarded with no out_valid.
  - The same bit is taken as bit 0 of a new frame: acc=in_bit, idx=1, stay in or enter DATA.
- Back-to-back frames: a frame's in_sof may arrive in the cycle right after its predecessor's parity bit. out_valid of the old frame and acceptance of the new bit 0 coincide, and both must work.
- out_data/out_err hold their last values while out_valid=0; they change only when a frame completes.
- err_count:
  - Increments in the same cycle out_valid=1 with out_err=1.
  - Saturates at 2^ERR_CNT_W-1.
  - clr_count sets it to 0. clr_count has priority over a simultaneous increment, and that increment is lost.
- No backpressure: the consumer must accept out_valid pulses unconditionally.

Decomposition:
- Shared package parity_pkg:
  - state enum {IDLE, DATA, PARITY}
  - PARITY_EVEN=0, PARITY_ODD=1
  - default DATA_W=4, ERR_CNT_W=8
- One sub-module, sat_counter (parameter W; ports inc, clr, count). It is reused by other link-statistics blocks.

Test Plan:
- Even parity, data 4'b1011 sent LSB first as bits 1,1,0,1, parity 1 -> one cycle after the parity bit: out_valid=1, out_data=4'hB, out_err=0, err_count=0.
- Same data with parity 0 -> out_err=1, err_count=1. Repeat 300 errored frames with ERR_CNT_W=8 -> err_count saturates at 255.
- in_sof asserted at data bit 2 of a frame -> abort pulse next cycle, no out_valid. The new frame 4'h5 with parity 0 then completes with out_data=4'h5, out_err=0.
- Back-to-back frames 4'hF/p0 then 4'h1/p1 with no idle cycles -> two out_valid pulses 5 cycles apart, data F then 1, both out_err=0. With in_valid gaps inserted, the results are identical.
- clr_count asserted in the same cycle as an errored out_valid when err_count=7 -> err_count=0 the next cycle.
- ODD=1: data 4'h0 with parity 1 -> out_err=0. rst_n pulsed low mid-frame -> all outputs return to 0 immediately, and the partial frame produces no output.
